fft_buf_reader: RTL

Streaming read-out engine for the 2048x32 single-port FFT sample buffer. Each entry packs a 16-bit real part in [31:16] and a 16-bit imaginary part in [15:0]. On start it sweeps N = 2^len_log2 entries, in natural or bit-reversed order, and presents them as a valid/ready complex stream to the downstream stage (demapper/UART tx). It owns the RAM port only while busy; the write-side engine owns it otherwise.

---
 rtl/fft_buf_reader_if.sv | 33 +++
 rtl/fft_buf_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_buf_reader_if.sv
// RAM read port plus the outgoing complex-sample stream of the FFT buffer reader.
// master = the reader engine, slave = RAM model / downstream consumer.
interface fft_buf_reader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) ();
  logic                  ram_ce;
  logic                  ram_oce;
  logic                  ram_wre;
  logic [ADDR_W-1:0]     ram_ad;
  logic [DATA_W-1:0]     ram_dout;

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_W/2-1:0]   m_re;
  logic [DATA_W/2-1:0]   m_im;
  logic [ADDR_W-1:0]     m_index;
  logic                  m_last;

  modport master (
    output ram_ce, ram_oce, ram_wre, ram_ad,
    input  ram_dout,
    output m_valid, m_re, m_im, m_index, m_last,
    input  m_ready
  );

  modport slave (
    input  ram_ce, ram_oce, ram_wre, ram_ad,
    output ram_dout,
    input  m_valid, m_re, m_im, m_index, m_last,
    output m_ready
  );
endinterface

// File: rtl/fft_buf_reader.sv
// Sweeps 2^len_log2 entries of the FFT sample buffer in natural or bit-reversed
// order and streams them out as valid/ready complex beats tagged with their index.
module fft_buf_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  len_log2,
  input  logic        bitrev,
  output logic        busy,
  output logic        done,
  fft_buf_reader_if.master bus
);
  localparam int         HALF_W  = DATA_W / 2;
  localparam int         CNT_W   = ADDR_W + 1;
  localparam logic [3:0] LEN_MAX = 4'(ADDR_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [3:0]         len_q, len_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic               bitrev_q, bitrev_d;
  logic               done_q, done_d;

  logic               inflight_q, inflight_d;
  logic [ADDR_W-1:0]  tag_q, tag_d;

  logic [1:0]         fifo_cnt_q, fifo_cnt_d;
  logic               fifo_rd_q, fifo_rd_d;
  logic               fifo_wr_q, fifo_wr_d;
  logic [DATA_W-1:0]  fifo_data_q [2];
  logic [ADDR_W-1:0]  fifo_idx_q [2];
  logic               fifo_last_q [2];
  logic               fifo_push;
  logic               fifo_pop;

  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [ADDR_W-1:0]  out_idx_q, out_idx_d;
  logic               out_last_q, out_last_d;

  logic [3:0]         len_clamped;
  logic [ADDR_W-1:0]  k_rev_full;
  logic [ADDR_W-1:0]  k_rev;
  logic [ADDR_W-1:0]  issue_addr;
  logic [2:0]         occupancy;
  logic               issue;
  logic               in_last;
  logic               pop_out;

  assign len_clamped = (len_log2 > LEN_MAX) ? LEN_MAX : len_log2;

  // Reverse all ADDR_W bits, then shift down so only the low len_q bits take part.
  generate
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_rev
      assign k_rev_full[gi] = k_q[ADDR_W-1-gi];
    end
  endgenerate

  assign k_rev      = k_rev_full >> (LEN_MAX - len_q);
  assign issue_addr = bitrev_q ? k_rev : k_q[ADDR_W-1:0];

  // FIFO slots plus the read in flight; the output register is separate storage.
  assign occupancy = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
  assign issue     = (state_q == S_RUN) && (k_q < n_q) && (occupancy + 3'd1 <= 3'd2);
  assign in_last   = ({1'b0, tag_q} == (n_q - CNT_W'(1)));
  assign pop_out   = out_valid_q & bus.m_ready;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    n_d      = n_q;
    k_d      = k_q;
    bitrev_d = bitrev_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = len_clamped;
          n_d      = CNT_W'(1) << len_clamped;
          bitrev_d = bitrev;
          k_d      = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          k_d = k_q + CNT_W'(1);
          if (k_d == n_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop_out && out_last_q && (fifo_cnt_q == 2'd0) && !inflight_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d  = issue;
    tag_d       = issue ? k_q[ADDR_W-1:0] : tag_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_rd_d   = fifo_rd_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_cnt_d  = fifo_cnt_q;

    // Refill the output register when it is empty or being accepted; the FIFO
    // head has priority, otherwise returning RAM data bypasses straight through.
    if (!out_valid_q || pop_out) begin
      if (fifo_cnt_q != 2'd0) begin
        out_valid_d = 1'b1;
        out_data_d  = fifo_data_q[fifo_rd_q];
        out_idx_d   = fifo_idx_q[fifo_rd_q];
        out_last_d  = fifo_last_q[fifo_rd_q];
        fifo_pop    = 1'b1;
        fifo_push   = inflight_q;
      end else if (inflight_q) begin
        out_valid_d = 1'b1;
        out_data_d  = bus.ram_dout;
        out_idx_d   = tag_q;
        out_last_d  = in_last;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      fifo_push = inflight_q;
    end

    if (fifo_pop) begin
      fifo_rd_d = ~fifo_rd_q;
    end
    if (fifo_push) begin
      fifo_wr_d = ~fifo_wr_q;
    end
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      n_q         <= '0;
      k_q         <= '0;
      bitrev_q    <= 1'b0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
      tag_q       <= '0;
      fifo_cnt_q  <= '0;
      fifo_rd_q   <= 1'b0;
      fifo_wr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      n_q         <= n_d;
      k_q         <= k_d;
      bitrev_q    <= bitrev_d;
      done_q      <= done_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      fifo_cnt_q  <= fifo_cnt_d;
      fifo_rd_q   <= fifo_rd_d;
      fifo_wr_q   <= fifo_wr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
    end
  end

  // Storage only; emptiness is tracked by the pointers and count above.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_data_q[fifo_wr_q] <= bus.ram_dout;
      fifo_idx_q[fifo_wr_q]  <= tag_q;
      fifo_last_q[fifo_wr_q] <= in_last;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign bus.ram_ce  = issue;
  assign bus.ram_oce = issue;
  assign bus.ram_wre = 1'b0;
  assign bus.ram_ad  = issue ? issue_addr : '0;
  assign bus.m_valid = out_valid_q;
  assign bus.m_re    = out_data_q[DATA_W-1:HALF_W];
  assign bus.m_im    = out_data_q[HALF_W-1:0];
  assign bus.m_index = out_idx_q;
  assign bus.m_last  = out_last_q;
endmodule
